// File: rtl/x_load_arb.sv
// x_load_arb: round-robin arbiter/sequencer sharing one load/hold X register
// among NUM_REQ requesters. Each grant drives one load cycle, then captures
// the register output and returns it with a one-cycle ack.
// Optional feature macro: X_ARB_READBACK_CHK_EN (readback compare -> sticky err).
module x_load_arb #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_din,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  err,
    output logic [DW-1:0]         x_din,
    output logic                  x_load,
    output logic                  x_reset_l,
    input  logic [DW-1:0]         x_dout
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;

    logic [1:0]         state;
    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] cur_oh;

    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [PW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [DW-1:0]      win_data;
    logic [PW-1:0]      next_ptr;
    logic [PW-1:0]      cand;
    int unsigned        idx;

    assign busy = (state != ST_IDLE);

    // Round-robin pick: first eligible requester at or above ptr, wrapping;
    // the requester being acked this cycle is excluded.
    always_comb begin
        elig     = req & ~ack;
        found    = 1'b0;
        win_idx  = '0;
        win_oh   = '0;
        win_data = '0;
        idx      = 0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= 32'(NUM_REQ)) begin
                idx = idx - 32'(NUM_REQ);
            end
            cand = idx[PW-1:0];
            if (!found && elig[cand]) begin
                found        = 1'b1;
                win_idx      = cand;
                win_oh[cand] = 1'b1;
                win_data     = req_din[cand*DW +: DW];
            end
        end
        next_ptr = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Sequencer: IDLE -> LOAD (grant + load pulse) -> CAPT (capture + ack).
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            cur_oh <= '0;
            gnt    <= '0;
            ack    <= '0;
            rdata  <= '0;
            x_din  <= '0;
            x_load <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        x_din  <= win_data;
                        x_load <= 1'b1;
                        gnt    <= win_oh;
                        cur_oh <= win_oh;
                        ptr    <= next_ptr;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    x_load <= 1'b0;
                    gnt    <= '0;
                    state  <= ST_CAPT;
                end
                ST_CAPT: begin
                    rdata <= x_dout;
                    ack   <= cur_oh;
                    state <= ST_IDLE;
                end
                default: begin
                    x_load <= 1'b0;
                    gnt    <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef X_ARB_READBACK_CHK_EN
    // Sticky readback mismatch: register output must equal the value just loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == ST_CAPT && x_dout != x_din) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // X register reset: low while reset is high, released one cycle after.
    always_ff @(posedge clk) begin
        x_reset_l <= ~reset;
    end

endmodule

// File: tb/tb_x_load_arb.sv
// Self-checking bench for x_load_arb: reset, directed sequences, a vector
// table for simultaneous requests, and randomized traffic against a
// transaction-level reference model.
module tb_x_load_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NCYC = 700;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            err;
    logic [DW-1:0]   x_din;
    logic            x_load;
    logic            x_reset_l;
    logic [DW-1:0]   x_dout;

    logic [DW-1:0]   xreg;
    logic            force_zero;

    int vectors = 0;
    int errors  = 0;

    x_load_arb #(.NUM_REQ(N), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_din(req_din),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .err(err),
        .x_din(x_din), .x_load(x_load), .x_reset_l(x_reset_l), .x_dout(x_dout)
    );

    always #5 clk = ~clk;

    // X register model: sync active-low reset, load/hold; output can be forced to 0
    always @(posedge clk) begin
        if (!x_reset_l) xreg <= '0;
        else if (x_load) xreg <= x_din;
    end
    assign x_dout = force_zero ? '0 : xreg;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       busy;
        logic       xload;
        logic [7:0] xdin;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl [14];

    logic [3:0] exp_gnt  [NCYC+4];
    logic [3:0] exp_ack  [NCYC+4];
    logic       exp_busy [NCYC+4];
    logic [7:0] exp_gdat [NCYC+4];
    logic [7:0] exp_adat [NCYC+4];
    int         a_st [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    function automatic logic [7:0] slice(input logic [N*DW-1:0] d, input int i);
        return d[i*DW +: DW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_err;
        int   free_at, m_ptr, w;
        logic [3:0] elig;
        logic [7:0] m_xdin, m_rdata;

        reset = 1'b1; req = '0; req_din = '0; force_zero = 1'b0;

        // vector table: all four requesting, each dropped on its ack cycle
        tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 8'h11, 8'h00};
        tbl[2]  = '{4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 8'h11, 8'h00};
        tbl[3]  = '{4'hE, 4'h0, 4'h1, 1'b0, 1'b0, 8'h11, 8'h11};
        tbl[4]  = '{4'hE, 4'h2, 4'h0, 1'b1, 1'b1, 8'h22, 8'h11};
        tbl[5]  = '{4'hE, 4'h0, 4'h0, 1'b1, 1'b0, 8'h22, 8'h11};
        tbl[6]  = '{4'hC, 4'h0, 4'h2, 1'b0, 1'b0, 8'h22, 8'h22};
        tbl[7]  = '{4'hC, 4'h4, 4'h0, 1'b1, 1'b1, 8'h33, 8'h22};
        tbl[8]  = '{4'hC, 4'h0, 4'h0, 1'b1, 1'b0, 8'h33, 8'h22};
        tbl[9]  = '{4'h8, 4'h0, 4'h4, 1'b0, 1'b0, 8'h33, 8'h33};
        tbl[10] = '{4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 8'h44, 8'h33};
        tbl[11] = '{4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 8'h44, 8'h33};
        tbl[12] = '{4'h0, 4'h0, 4'h8, 1'b0, 1'b0, 8'h44, 8'h44};
        tbl[13] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h44, 8'h44};

        // ---- reset held 3 cycles ----
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_ack", 32'(ack), 0);
            chk("rst_rdata", 32'(rdata), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_xdin", 32'(x_din), 0);
            chk("rst_xload", 32'(x_load), 0);
            chk("rst_xreset_l", 32'(x_reset_l), 0);
        end
        reset = 1'b0;
        tick();
        chk("rst_release_xreset_l", 32'(x_reset_l), 1);
        chk("rst_release_busy", 32'(busy), 0);

        // ---- single request ----
        do_reset();
        req = 4'b0001; req_din = {8'h00, 8'h00, 8'h00, 8'h5A};
        chk("single_busy0", 32'(busy), 0);
        tick();
        chk("single_gnt1", 32'(gnt), 32'h1);
        chk("single_xload1", 32'(x_load), 1);
        chk("single_xdin1", 32'(x_din), 32'h5A);
        chk("single_busy1", 32'(busy), 1);
        tick();
        chk("single_gnt2", 32'(gnt), 0);
        chk("single_xload2", 32'(x_load), 0);
        chk("single_busy2", 32'(busy), 1);
        chk("single_ack2", 32'(ack), 0);
        tick();
        chk("single_ack3", 32'(ack), 32'h1);
        chk("single_rdata3", 32'(rdata), 32'h5A);
        chk("single_busy3", 32'(busy), 0);
        req = '0;
        tick();
        chk("single_ack4", 32'(ack), 0);
        chk("single_rdata_hold", 32'(rdata), 32'h5A);
        chk("single_busy4", 32'(busy), 0);

        // ---- table: all requesters at once ----
        do_reset();
        req_din = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 14; i++) begin
            if (i > 0) tick();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_xload", i), 32'(x_load), 32'(tbl[i].xload));
            chk($sformatf("tbl%0d_xdin", i), 32'(x_din), 32'(tbl[i].xdin));
            chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].rdata));
            req = tbl[i].req;
        end

        // ---- fairness: req[0] and req[2] held for 12 transfers ----
        do_reset();
        req = 4'b0101; req_din = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int c = 1; c <= 36; c++) begin
            tick();
            if ((c % 3) == 1)
                chk($sformatf("fair_gnt_c%0d", c), 32'(gnt), ((c / 3) % 2 == 0) ? 32'h1 : 32'h4);
            else
                chk($sformatf("fair_gnt_c%0d", c), 32'(gnt), 0);
        end
        req = '0;

        // ---- reset during LOAD of a req[1] transfer ----
        do_reset();
        req = 4'b0010; req_din = {8'h00, 8'h00, 8'h77, 8'h3C};
        tick();
        chk("rmid_gnt_load", 32'(gnt), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_xload", 32'(x_load), 0);
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_ack", 32'(ack), 0);
        req = 4'b0011;
        tick();
        chk("rmid_ptr0_gnt", 32'(gnt), 32'h1);
        req = 4'b0001;
        for (int c = 4; c <= 9; c++) begin
            tick();
            chk($sformatf("rmid_no_ack1_c%0d", c), 32'(ack[1]), 0);
            if (c == 5) begin
                chk("rmid_ack0", 32'(ack), 32'h1);
                chk("rmid_rdata", 32'(rdata), 32'h3C);
                req = '0;
            end
        end

        // ---- randomized traffic vs transaction-level model ----
        do_reset();
        for (int i = 0; i < NCYC + 4; i++) begin
            exp_gnt[i] = '0; exp_ack[i] = '0; exp_busy[i] = 1'b0;
            exp_gdat[i] = '0; exp_adat[i] = '0;
        end
        for (int i = 0; i < N; i++) a_st[i] = 0;
        free_at = 0; m_ptr = 0; m_xdin = '0; m_rdata = '0;
        for (int t = 0; t < NCYC; t++) begin
            if (t > 0) tick();
            if (exp_gnt[t] != 0) m_xdin = exp_gdat[t];
            if (exp_ack[t] != 0) m_rdata = exp_adat[t];
            chk($sformatf("rnd%0d_gnt", t), 32'(gnt), 32'(exp_gnt[t]));
            chk($sformatf("rnd%0d_ack", t), 32'(ack), 32'(exp_ack[t]));
            chk($sformatf("rnd%0d_busy", t), 32'(busy), 32'(exp_busy[t]));
            chk($sformatf("rnd%0d_xload", t), 32'(x_load), (exp_gnt[t] != 0) ? 1 : 0);
            chk($sformatf("rnd%0d_xdin", t), 32'(x_din), 32'(m_xdin));
            chk($sformatf("rnd%0d_rdata", t), 32'(rdata), 32'(m_rdata));
            chk($sformatf("rnd%0d_err", t), 32'(err), 0);
            // requester agents
            for (int i = 0; i < N; i++) begin
                if (a_st[i] == 1) begin
                    if (exp_gnt[t][i]) begin
                        a_st[i] = 2;
                        req_din[i*DW +: DW] = 8'($urandom);
                    end else if ($urandom_range(15) == 0) begin
                        req[i] = 1'b0; a_st[i] = 0;
                    end
                end else if (a_st[i] == 2) begin
                    if (exp_ack[t][i]) begin
                        if ($urandom_range(1) == 1) begin
                            req_din[i*DW +: DW] = 8'($urandom); a_st[i] = 1;
                        end else begin
                            req[i] = 1'b0; a_st[i] = 0;
                        end
                    end
                end else if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1; req_din[i*DW +: DW] = 8'($urandom); a_st[i] = 1;
                end
            end
            // model: a free arbiter samples eligible requests and picks round-robin
            if (t >= free_at) begin
                elig = req & ~exp_ack[t];
                if (elig != 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    exp_gnt[t+1]  = 4'(1 << w);
                    exp_gdat[t+1] = slice(req_din, w);
                    exp_busy[t+1] = 1'b1;
                    exp_busy[t+2] = 1'b1;
                    exp_ack[t+3]  = 4'(1 << w);
                    exp_adat[t+3] = slice(req_din, w);
                    m_ptr   = (w + 1) % N;
                    free_at = t + 3;
                end
            end
        end
        req = '0;

        // ---- readback check with register output forced to zero ----
`ifdef X_ARB_READBACK_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        chk("rb_err_after_reset", 32'(err), 0);
        force_zero = 1'b1;
        req = 4'b0001; req_din = {8'h00, 8'h00, 8'h00, 8'hFF};
        tick();
        chk("rb_gnt", 32'(gnt), 32'h1);
        tick();
        chk("rb_err_before_ack", 32'(err), 0);
        tick();
        req = '0;
        chk("rb_ack", 32'(ack), 32'h1);
        chk("rb_rdata", 32'(rdata), 32'h00);
        chk("rb_err_ack", 32'(err), 32'(exp_err));
        for (int c = 4; c <= 6; c++) begin
            tick();
            chk($sformatf("rb_err_sticky_c%0d", c), 32'(err), 32'(exp_err));
        end
        force_zero = 1'b0;
        do_reset();
        chk("rb_err_cleared", 32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/x_load_arb.md
# x_load_arb

Round-robin arbiter and sequencer that shares one 8-bit load/hold register (the X register: `din`, `load`, `reset_l` in, `dout` out) among `NUM_REQ` requesters. It sits between the testbench-side request agents and the X register port. It serialises load transactions, drives `din`/`load` for exactly one cycle per grant, and returns the registered `dout` to the winning requester with a one-cycle `ack`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: data width; must match the X register.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  `NUM_REQ`  per-requester request level.
- `req_din`  in  `NUM_REQ*DW`  load data; slice i (bits i*DW +: DW) belongs to requester i.
- `gnt`  out  `NUM_REQ`  one-hot grant pulse, high during the load cycle.
- `ack`  out  `NUM_REQ`  one-hot completion pulse, one cycle.
- `rdata`  out  `DW`  X register `dout` captured for the completing transfer; valid while `ack` is high, held afterwards.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `err`  out  1  sticky readback mismatch flag (see Configuration).
- `x_din`  out  `DW`  to X register `din`.
- `x_load`  out  1  to X register `load`.
- `x_reset_l`  out  1  to X register `reset_l`, active-low.
- `x_dout`  in  `DW`  from X register `dout`.

## Operation
FSM states:
- **IDLE**:
  - Evaluate `req` masked by the current `ack` (a requester being acked this cycle is not eligible).
  - If any request is eligible, pick the winner by round-robin. Search starts at `ptr` and moves upward with wrap-around.
  - Register outputs: `x_din` <= winner's slice, `x_load` <= 1, `gnt` <= onehot(winner), `ptr` <= (winner+1) mod `NUM_REQ`. Go to LOAD.
- **LOAD**: `x_load` and `gnt` are visible. Register `x_load` <= 0 and `gnt` <= 0. Go to CAPT.
- **CAPT**:
  - `x_dout` now holds the loaded value.
  - Register `rdata` <= `x_dout` and `ack` <= onehot(winner).
  - Perform the optional compare.
  - Go to IDLE.

Other rules:
- `x_din` holds its last value outside LOAD.
- `busy` is combinational from state (high when the state is not IDLE).
- Requester rules:
  - Hold `req` high and `req_din` stable from assertion until `gnt`.
  - `req_din` may change after `gnt`.
  - `req` may drop at any time after `ack`.
  - `req` still high on the cycle after `ack` counts as a new request.
- Dropping `req` before `gnt` withdraws the request with no side effects.
- `x_reset_l` is registered. It is 0 while `reset` is high and goes 1 on the first cycle after `reset` falls.

## Timing
- Request first sampled high in IDLE at cycle N:
  - `gnt`/`x_load` are high in cycle N+1.
  - The X register captures at the end of N+1.
  - `ack`/`rdata` are valid in cycle N+3.
- Maximum throughput is one transfer per 3 cycles. A request pending during an `ack` cycle is sampled that cycle and loads at N+4.
- Reset values:
  - outputs: `gnt`=0, `ack`=0, `rdata`=0, `busy`=0, `err`=0, `x_din`=0, `x_load`=0, `x_reset_l`=0
  - internal: state=IDLE, `ptr`=0
- Reset in any state:
  - Return to IDLE next cycle.
  - An in-flight transfer is abandoned: no `ack`, and `x_load` is low the next cycle.
- Simultaneous requests: exactly one grant per transfer. With all requesters active, grants rotate 0,1,..,`NUM_REQ`-1,0,...
- A requester that re-requests continuously cannot starve others: after its grant, `ptr` moves past it.

## Configuration
Macro `X_ARB_READBACK_CHK_EN`:
- **Defined**:
  - In CAPT, compare `x_dout` with `x_din`.
  - A mismatch sets `err` in the same cycle `ack` rises. `err` stays high until `reset`.
  - `ack`/`rdata` timing is unchanged and the transfer still completes.
- **Undefined**:
  - The compare logic is absent and `err` is tied to 0.
  - All other behaviour and timing are identical.

## Test plan
- **Reset**: hold `reset` for 3 cycles.
  - All outputs at reset values; `x_reset_l`=0 throughout.
  - `x_reset_l`=1 on the first cycle after `reset` falls.
- **Single request**: `req[0]` rises at cycle 0 with slice 0 = 0x5A.
  - Cycle 1: `gnt`=0001, `x_load`=1, `x_din`=0x5A.
  - Cycle 3: `ack`=0001, `rdata`=0x5A.
  - `busy` high in cycles 1–2.
- **All requesters at once**: `req`=1111 at cycle 0 with data 0x11, 0x22, 0x33, 0x44, each `req` dropped after its `ack`.
  - Grant order 0,1,2,3.
  - `ack` in cycles 3, 6, 9, 12 with `rdata` 0x11, 0x22, 0x33, 0x44.
- **Fairness**: `req[0]` and `req[2]` held high continuously for 12 transfers.
  - Grants alternate 0,2,0,2,...
  - `gnt[1]` and `gnt[3]` never assert.
- **Reset mid-transfer**: assert `reset` during the LOAD cycle of a `req[1]` transfer.
  - `x_load`=0 and `busy`=0 next cycle; no `ack[1]` ever.
  - After release, `req[0]` and `req[1]` requesting together get requester 0 granted first (`ptr`=0).
- **Readback check**: the X register model forces `x_dout`=0x00 while a 0xFF load is issued.
  - With `X_ARB_READBACK_CHK_EN`: `err`=1 from the `ack` cycle onward, `ack` still pulses, `rdata`=0x00.
  - Without the macro: `err` stays 0.
